// File: rtl/sccb_pkg.sv
// Shared types and helpers for the SCCB write master: FSM states, quarter
// indices and the quarter-period divider calculation.
package sccb_pkg;

   typedef enum logic [3:0] {
      IDLE,
      START,
      SLA,
      ACK1,
      REG,
      ACK2,
      DAT,
      ACK3,
      STOP,
      DONE
   } state_t;

   localparam logic [1:0] Q0 = 2'd0;
   localparam logic [1:0] Q1 = 2'd1;
   localparam logic [1:0] Q2 = 2'd2;
   localparam logic [1:0] Q3 = 2'd3;

   // Clocks per quarter of an SCL period.
   function automatic int calc_div(input int clk_freq, input int scl_freq);
      return clk_freq / (scl_freq * 4);
   endfunction

endpackage

// File: rtl/sccb_qtick_gen.sv
// Quarter-period timebase: a DIV-clock prescaler that emits qtick on the last
// clock of each quarter and steps a 2-bit quarter index q0..q3.
module sccb_qtick_gen
   import sccb_pkg::*;
#(
   parameter int DIV = 50
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   output logic       qtick,
   output logic [1:0] quarter
);

   localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] count;

   assign qtick = (count == LAST);

   // Holding the counter in clear while idle makes the first slot of every
   // frame start exactly on the accept edge.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count   <= '0;
         quarter <= Q0;
      end else if (qtick) begin
         count   <= '0;
         quarter <= quarter + 2'd1;
      end else begin
         count   <= count + CW'(1);
      end
   end

endmodule

// File: rtl/sccb_write_master.sv
// SCCB/I2C three-phase write master: START, {addr,W}, reg_addr, reg_data,
// STOP, then a one-cycle done pulse carrying the accumulated NACK flag.
module sccb_write_master
   import sccb_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR = 7'h21,
   parameter int         CLK_FREQ   = 50_000_000,
   parameter int         SCL_FREQ   = 250_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i2c_exec,
   input  logic [15:0] i2c_data,
   output logic        i2c_done,
   output logic        i2c_ack,
   output logic        busy,
   output logic        scl,
   output logic        sda_out,
   output logic        sda_oe,
   input  logic        sda_in
);

   localparam int DIV = calc_div(CLK_FREQ, SCL_FREQ);

   if (DIV < 2) begin : g_bad_div
      $error("sccb_write_master: CLK_FREQ/(SCL_FREQ*4) must be at least 2");
   end

   state_t      state;
   state_t      state_next;
   logic [23:0] shreg;
   logic [2:0]  bit_cnt;
   logic        nack;
   logic        qtick;
   logic [1:0]  quarter;
   logic        slot_end;
   logic        accept;
   logic        in_byte;
   logic        in_ack;
   logic        tick_clear;

   assign accept     = (state == IDLE) && i2c_exec;
   assign slot_end   = qtick && (quarter == Q3);
   assign in_byte    = (state == SLA) || (state == REG) || (state == DAT);
   assign in_ack     = (state == ACK1) || (state == ACK2) || (state == ACK3);
   assign tick_clear = (state == IDLE) || (state == DONE);

   sccb_qtick_gen #(.DIV(DIV)) u_qtick (
      .clk     (clk),
      .rst     (rst),
      .clear   (tick_clear),
      .qtick   (qtick),
      .quarter (quarter)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Every state except DONE lasts whole slots; byte states repeat for eight.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:  if (i2c_exec) state_next = START;
         START: if (slot_end) state_next = SLA;
         SLA:   if (slot_end && bit_cnt == 3'd7) state_next = ACK1;
         ACK1:  if (slot_end) state_next = REG;
         REG:   if (slot_end && bit_cnt == 3'd7) state_next = ACK2;
         ACK2:  if (slot_end) state_next = DAT;
         DAT:   if (slot_end && bit_cnt == 3'd7) state_next = ACK3;
         ACK3:  if (slot_end) state_next = STOP;
         STOP:  if (slot_end) state_next = DONE;
         DONE:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Shifting at the slot end presents the next bit on SDA from q0 onward.
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg   <= '0;
         bit_cnt <= '0;
         nack    <= 1'b0;
         i2c_ack <= 1'b0;
      end else if (accept) begin
         shreg   <= {SLAVE_ADDR, 1'b0, i2c_data};
         bit_cnt <= '0;
         nack    <= 1'b0;
         i2c_ack <= 1'b0;
      end else begin
         if (in_byte && slot_end) begin
            shreg   <= {shreg[22:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
         end
         if (in_ack && qtick && quarter == Q2) begin
            nack <= nack | sda_in;
         end
         if (state == STOP && slot_end) begin
            i2c_ack <= nack;
         end
      end
   end

   // Pin levels decode only registered state, so they change on clock edges.
   always_comb begin
      scl     = 1'b1;
      sda_out = 1'b0;
      sda_oe  = 1'b0;
      case (state)
         START: begin
            sda_oe  = 1'b1;
            sda_out = ~quarter[1];
         end
         SLA, REG, DAT: begin
            scl     = quarter[1];
            sda_oe  = 1'b1;
            sda_out = shreg[23];
         end
         ACK1, ACK2, ACK3: begin
            scl = quarter[1];
         end
         STOP: begin
            scl    = (quarter != Q0);
            sda_oe = (quarter != Q3);
         end
         default: begin
            scl = 1'b1;
         end
      endcase
   end

   assign i2c_done = (state == DONE);
   assign busy     = (state != IDLE);

endmodule

// File: doc/sccb_write_master.md
# sccb_write_master

SCCB/I2C write master that executes the 3-phase register writes issued by the camera configuration sequencer. It accepts one 16-bit `{reg_addr, reg_data}` word per `i2c_exec` pulse and serialises `{SLAVE_ADDR,W}`, `reg_addr` and `reg_data` onto SCL/SDA. It pulses `i2c_done` when the STOP condition completes. It sits between the config sequencer and the OV7725 SCCB pins.

## Interface
- `SLAVE_ADDR`, 7'h21: 7-bit device address. The first byte on the wire is `{SLAVE_ADDR,1'b0}` = 8'h42.
- `CLK_FREQ`, 50_000_000: `clk` frequency in Hz.
- `SCL_FREQ`, 250_000: SCL frequency in Hz.
- `clk` in 1: system clock. Single clock domain.
- `rst` in 1: reset, synchronous and active-high.
- `i2c_exec` in 1: one-cycle start request.
- `i2c_data` in 16: `{reg_addr[15:8], reg_data[7:0]}`. Sampled only in the cycle `i2c_exec` is accepted.
- `i2c_done` out 1: one-cycle pulse when a transaction ends.
- `i2c_ack` out 1: set if any of the three ACK slots sampled SDA high (NACK). Valid with `i2c_done`; held until the next accept.
- `busy` out 1: high from accept until the `i2c_done` cycle, inclusive.
- `scl` out 1: SCCB clock. Push-pull.
- `sda_out` out 1: SDA drive value.
- `sda_oe` out 1: SDA output enable. The top level builds the pin as `sda = sda_oe ? sda_out : Z`.
- `sda_in` in 1: SDA pad readback.

## Operation
- `DIV = CLK_FREQ/(SCL_FREQ*4)`, which is 50 at the defaults. A free-running `qtick` fires every DIV clocks while not IDLE. DIV < 2 is an elaboration error.
- A bit slot is four quarters, q0..q3, each DIV clocks long.
- Data slots:
  - SCL is low in q0–q1 and high in q2–q3.
  - SDA is updated at the start of q0.
  - `sda_in` is sampled on the last clock of q2.
- States: IDLE → START → SLA(8) → ACK1 → REG(8) → ACK2 → DAT(8) → ACK3 → STOP → DONE → IDLE. That is 29 slots in total, START and STOP counted as one slot each.
- IDLE:
  - `scl`=1, `sda_oe`=0.
  - `i2c_exec`=1 latches `i2c_data` into a shift register, clears the NACK flag, sets `busy`, and enters START.
- START slot: SDA is driven 1 in q0–q1 and 0 in q2–q3. SCL stays 1 throughout.
- Byte slots:
  - MSB first.
  - `sda_oe`=1 and `sda_out`=bit.
  - A 3-bit bit counter wraps from 7 to 0 into the ACK state.
- ACK slots:
  - `sda_oe`=0.
  - The sampled value is ORed into the NACK flag.
  - A NACK does not abort the transfer; SCCB treats ACK as don't-care.
- STOP slot:
  - q0: SCL=0, SDA driven 0.
  - q1–q2: SCL=1, SDA driven 0.
  - q3: SCL=1, `sda_oe`=0 (released high).
- DONE: one cycle. `i2c_done`=1 and `i2c_ack` takes the NACK flag. Then IDLE with `busy`=0.
- `i2c_exec` while `busy` is ignored; no queueing.
- `i2c_exec` in the same cycle as DONE is ignored. It is accepted from the following IDLE cycle.
- Reset values: `scl`=1, `sda_out`=0, `sda_oe`=0, `i2c_done`=0, `i2c_ack`=0, `busy`=0, state=IDLE, all counters 0.
- Reset mid-transfer: the block is in IDLE the next cycle, the bus is released, and no `i2c_done` is produced.

## Timing
- Accept at cycle T, meaning `i2c_exec` is sampled high in IDLE.
- The START slot begins at T+1.
- `i2c_done` is high exactly at T+1+116·DIV. At the defaults this is T+5801.
- `busy` is high over [T+1, T+1+116·DIV].
- The earliest next accept is T+2+116·DIV.
- Each SCL high phase lasts 2·DIV clocks. SDA never changes while SCL is high, except in the START q2 and STOP q3 transitions.
- `i2c_ack` updates in the same cycle as `i2c_done`.

## Structure
- Package `sccb_pkg`:
  - state enum: IDLE, START, SLA, ACK1, REG, ACK2, DAT, ACK3, STOP, DONE.
  - `DIV` function.
  - quarter indices.
- Sub-module `sccb_qtick_gen`:
  - DIV counter with synchronous clear on IDLE.
  - Outputs the `qtick` pulse and a 2-bit quarter index.
- Top level: FSM, 24-bit shift register, bit counter, NACK flag.

## Test plan
- Single write:
  - Stimulus: `i2c_data`=16'h1280, exec at T, bus model ACKs.
  - Response: the bus model decodes bytes 42,12,80 with START and STOP; `i2c_done` at T+5801; `i2c_ack`=0.
- NACK on register byte:
  - Stimulus: bus model leaves SDA high in ACK2 for 16'h3D03.
  - Response: the transaction still completes; `i2c_done` at T+5801; `i2c_ack`=1.
- Exec while busy:
  - Stimulus: pulse exec with 16'hFFFF at T+100.
  - Response: ignored; the bus shows only the first word; exactly one done pulse.
- Back-to-back writes:
  - Stimulus: exec issued one cycle after each done, for words 1280 then 3D03.
  - Response: two complete frames; second done at T+11603; bus released in between.
- Reset mid-transfer:
  - Stimulus: assert `rst` for 1 cycle during DAT.
  - Response: `scl`=1, `sda_oe`=0, `busy`=0 next cycle; no done; a new exec then completes normally.
- Protocol checker, run throughout all scenarios: SDA is stable while SCL is high except at START/STOP; 29 slots per frame, each 4·DIV clocks.
